axi_mem_responder: RTL and testbench

AXI_MEM_RESPONDER -- requirements
Module: axi_mem_responder

---
 rtl/axi_mem_responder_if.sv | 78 +++++++
 rtl/axi_mem_responder.sv | 237 +++++++++++++++++++++++
 tb/tb_axi_mem_responder.sv | 267 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/axi_mem_responder_if.sv
// rtl/axi_mem_responder_if.sv - AXI4 bus bundle between the MMU master and the memory responder
//
// Purpose: groups the five AXI4 channels (AW, W, B, AR, R) into one bundle.
//   slave  modport: used by axi_mem_responder (drives the READY/response side).
//   master modport: used by the requesting side (core MMU or testbench).
// Signals:
//   AW: S_AXI_AWID[3:0], S_AXI_AWADDR, S_AXI_AWLEN[7:0], S_AXI_AWSIZE[2:0],
//       S_AXI_AWBURST[1:0], S_AXI_AWVALID, S_AXI_AWREADY
//   W : S_AXI_WDATA, S_AXI_WSTRB, S_AXI_WLAST, S_AXI_WVALID, S_AXI_WREADY
//   B : S_AXI_BID[3:0], S_AXI_BRESP[1:0], S_AXI_BVALID, S_AXI_BREADY
//   AR: S_AXI_ARID[3:0], S_AXI_ARADDR, S_AXI_ARLEN[7:0], S_AXI_ARSIZE[2:0],
//       S_AXI_ARBURST[1:0], S_AXI_ARVALID, S_AXI_ARREADY
//   R : S_AXI_RID[3:0], S_AXI_RDATA, S_AXI_RRESP[1:0], S_AXI_RLAST,
//       S_AXI_RVALID, S_AXI_RREADY
interface axi_mem_responder_if #(
    parameter int C_AXI_DATA_WIDTH = 32,
    parameter int C_OFFSET_WIDTH   = 32
);
    logic [3:0]                    S_AXI_AWID;
    logic [C_OFFSET_WIDTH-1:0]     S_AXI_AWADDR;
    logic [7:0]                    S_AXI_AWLEN;
    logic [2:0]                    S_AXI_AWSIZE;
    logic [1:0]                    S_AXI_AWBURST;
    logic                          S_AXI_AWVALID;
    logic                          S_AXI_AWREADY;

    logic [C_AXI_DATA_WIDTH-1:0]   S_AXI_WDATA;
    logic [C_AXI_DATA_WIDTH/8-1:0] S_AXI_WSTRB;
    logic                          S_AXI_WLAST;
    logic                          S_AXI_WVALID;
    logic                          S_AXI_WREADY;

    logic [3:0]                    S_AXI_BID;
    logic [1:0]                    S_AXI_BRESP;
    logic                          S_AXI_BVALID;
    logic                          S_AXI_BREADY;

    logic [3:0]                    S_AXI_ARID;
    logic [C_OFFSET_WIDTH-1:0]     S_AXI_ARADDR;
    logic [7:0]                    S_AXI_ARLEN;
    logic [2:0]                    S_AXI_ARSIZE;
    logic [1:0]                    S_AXI_ARBURST;
    logic                          S_AXI_ARVALID;
    logic                          S_AXI_ARREADY;

    logic [3:0]                    S_AXI_RID;
    logic [C_AXI_DATA_WIDTH-1:0]   S_AXI_RDATA;
    logic [1:0]                    S_AXI_RRESP;
    logic                          S_AXI_RLAST;
    logic                          S_AXI_RVALID;
    logic                          S_AXI_RREADY;

    modport slave (
        input  S_AXI_AWID, S_AXI_AWADDR, S_AXI_AWLEN, S_AXI_AWSIZE, S_AXI_AWBURST, S_AXI_AWVALID,
        output S_AXI_AWREADY,
        input  S_AXI_WDATA, S_AXI_WSTRB, S_AXI_WLAST, S_AXI_WVALID,
        output S_AXI_WREADY,
        output S_AXI_BID, S_AXI_BRESP, S_AXI_BVALID,
        input  S_AXI_BREADY,
        input  S_AXI_ARID, S_AXI_ARADDR, S_AXI_ARLEN, S_AXI_ARSIZE, S_AXI_ARBURST, S_AXI_ARVALID,
        output S_AXI_ARREADY,
        output S_AXI_RID, S_AXI_RDATA, S_AXI_RRESP, S_AXI_RLAST, S_AXI_RVALID,
        input  S_AXI_RREADY
    );

    modport master (
        output S_AXI_AWID, S_AXI_AWADDR, S_AXI_AWLEN, S_AXI_AWSIZE, S_AXI_AWBURST, S_AXI_AWVALID,
        input  S_AXI_AWREADY,
        output S_AXI_WDATA, S_AXI_WSTRB, S_AXI_WLAST, S_AXI_WVALID,
        input  S_AXI_WREADY,
        input  S_AXI_BID, S_AXI_BRESP, S_AXI_BVALID,
        output S_AXI_BREADY,
        output S_AXI_ARID, S_AXI_ARADDR, S_AXI_ARLEN, S_AXI_ARSIZE, S_AXI_ARBURST, S_AXI_ARVALID,
        input  S_AXI_ARREADY,
        input  S_AXI_RID, S_AXI_RDATA, S_AXI_RRESP, S_AXI_RLAST, S_AXI_RVALID,
        output S_AXI_RREADY
    );
endinterface

// File: rtl/axi_mem_responder.sv
// rtl/axi_mem_responder.sv - AXI4 slave backed by a word-addressed on-chip memory
//
// Purpose: memory end of the MMU's AXI4 master. Independent write and read
//   state machines share one byte-writable memory of 2**MEM_WORDS_LOG2 words.
// Ports:
//   CLK   : sole clock, rising edge
//   RST   : synchronous active-high reset (memory contents are not touched)
//   s_axi : axi_mem_responder_if.slave, all five AXI4 channels
module axi_mem_responder #(
    parameter int C_AXI_DATA_WIDTH = 32,
    parameter int C_OFFSET_WIDTH   = 32,
    parameter int MEM_WORDS_LOG2   = 12
) (
    input  logic                CLK,
    input  logic                RST,
    axi_mem_responder_if.slave  s_axi
);
    localparam int DW     = C_AXI_DATA_WIDTH;
    localparam int AW     = C_OFFSET_WIDTH;
    localparam int NB     = DW / 8;
    localparam int DEPTH  = 1 << MEM_WORDS_LOG2;
    localparam int IDX_HI = MEM_WORDS_LOG2 + 1;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;
    localparam logic [2:0] SIZE_WORD   = 3'b010;

    typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_t;
    typedef enum logic [1:0] {R_IDLE, R_FETCH, R_DATA} r_state_t;

    // Any address bit above the word index selects nothing.
    function automatic logic in_range(input logic [AW-1:0] a);
        return (a >> (MEM_WORDS_LOG2 + 2)) == '0;
    endfunction

    // FIXED bursts stay on one word; INCR, WRAP (treated as INCR) and the
    // reserved encoding advance by one word, wrapping modulo 2**AW.
    function automatic logic [AW-1:0] addr_step(input logic [1:0] burst);
        return (burst == 2'b00) ? '0 : AW'(4);
    endfunction

    // Response encodings order by severity numerically: DECERR > SLVERR > OKAY.
    function automatic logic [1:0] worst(input logic [1:0] a, input logic [1:0] b);
        return (a > b) ? a : b;
    endfunction

    logic [DW-1:0] mem [0:DEPTH-1];

    // ---------------------------------------------------------------- write
    w_state_t                  w_state_q;
    logic [3:0]                aw_id_q;
    logic [AW-1:0]             aw_addr_q;
    logic [7:0]                aw_len_q;
    logic [2:0]                aw_size_q;
    logic [1:0]                aw_burst_q;
    logic [7:0]                w_cnt_q;
    logic [1:0]                b_resp_q;

    logic                      w_fire;
    logic                      w_last_beat;
    logic                      w_in_range;
    logic                      mem_we;
    logic [MEM_WORDS_LOG2-1:0] w_idx;
    logic [AW-1:0]             aw_addr_d;
    logic [1:0]                w_beat_resp_d;

    assign w_fire      = (w_state_q == W_DATA) && s_axi.S_AXI_WVALID;
    assign w_last_beat = (w_cnt_q == aw_len_q);
    assign w_in_range  = in_range(aw_addr_q);
    assign w_idx       = aw_addr_q[IDX_HI:2];
    assign aw_addr_d   = aw_addr_q + addr_step(aw_burst_q);
    // Out-of-range beats are dropped; a beat arriving in the reset cycle is
    // discarded so reset never alters memory.
    assign mem_we      = w_fire && w_in_range && !RST;

    always_comb begin
        w_beat_resp_d = RESP_OKAY;
        if ((aw_size_q != SIZE_WORD) || (s_axi.S_AXI_WLAST != w_last_beat)) begin
            w_beat_resp_d = RESP_SLVERR;
        end
        if (!w_in_range) begin
            w_beat_resp_d = RESP_DECERR;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            w_state_q  <= W_IDLE;
            aw_id_q    <= '0;
            aw_addr_q  <= '0;
            aw_len_q   <= '0;
            aw_size_q  <= '0;
            aw_burst_q <= '0;
            w_cnt_q    <= '0;
            b_resp_q   <= RESP_OKAY;
        end else begin
            case (w_state_q)
                W_IDLE: begin
                    if (s_axi.S_AXI_AWVALID) begin
                        aw_id_q    <= s_axi.S_AXI_AWID;
                        aw_addr_q  <= s_axi.S_AXI_AWADDR;
                        aw_len_q   <= s_axi.S_AXI_AWLEN;
                        aw_size_q  <= s_axi.S_AXI_AWSIZE;
                        aw_burst_q <= s_axi.S_AXI_AWBURST;
                        w_cnt_q    <= '0;
                        b_resp_q   <= RESP_OKAY;
                        w_state_q  <= W_DATA;
                    end
                end
                W_DATA: begin
                    if (s_axi.S_AXI_WVALID) begin
                        // BRESP accumulates the worst beat of the whole burst.
                        b_resp_q <= worst(b_resp_q, w_beat_resp_d);
                        if (w_last_beat) begin
                            w_state_q <= W_RESP;
                        end else begin
                            w_cnt_q   <= w_cnt_q + 8'd1;
                            aw_addr_q <= aw_addr_d;
                        end
                    end
                end
                W_RESP: begin
                    if (s_axi.S_AXI_BREADY) begin
                        w_state_q <= W_IDLE;
                    end
                end
                default: w_state_q <= W_IDLE;
            endcase
        end
    end

    always_ff @(posedge CLK) begin
        if (mem_we) begin
            for (int b = 0; b < NB; b++) begin
                if (s_axi.S_AXI_WSTRB[b]) begin
                    mem[w_idx][b*8 +: 8] <= s_axi.S_AXI_WDATA[b*8 +: 8];
                end
            end
        end
    end

    assign s_axi.S_AXI_AWREADY = (w_state_q == W_IDLE);
    assign s_axi.S_AXI_WREADY  = (w_state_q == W_DATA);
    assign s_axi.S_AXI_BVALID  = (w_state_q == W_RESP);
    assign s_axi.S_AXI_BID     = aw_id_q;
    assign s_axi.S_AXI_BRESP   = b_resp_q;

    // ----------------------------------------------------------------- read
    r_state_t                  r_state_q;
    logic [3:0]                ar_id_q;
    logic [AW-1:0]             ar_addr_q;
    logic [7:0]                ar_len_q;
    logic [2:0]                ar_size_q;
    logic [1:0]                ar_burst_q;
    logic [7:0]                r_cnt_q;
    logic [DW-1:0]             rdata_q;
    logic [1:0]                rresp_q;
    logic                      rlast_q;

    logic                      r_in_range;
    logic [MEM_WORDS_LOG2-1:0] r_idx;
    logic [AW-1:0]             ar_addr_d;
    logic [1:0]                r_beat_resp_d;

    assign r_in_range = in_range(ar_addr_q);
    assign r_idx      = ar_addr_q[IDX_HI:2];
    assign ar_addr_d  = ar_addr_q + addr_step(ar_burst_q);

    always_comb begin
        r_beat_resp_d = RESP_OKAY;
        if (ar_size_q != SIZE_WORD) begin
            r_beat_resp_d = RESP_SLVERR;
        end
        if (!r_in_range) begin
            r_beat_resp_d = RESP_DECERR;
        end
    end

    // The R_FETCH memory read is a non-blocking sample of the array, so a
    // write to the same word in the same cycle is seen on the next access
    // only (read-first).
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state_q  <= R_IDLE;
            ar_id_q    <= '0;
            ar_addr_q  <= '0;
            ar_len_q   <= '0;
            ar_size_q  <= '0;
            ar_burst_q <= '0;
            r_cnt_q    <= '0;
            rdata_q    <= '0;
            rresp_q    <= RESP_OKAY;
            rlast_q    <= 1'b0;
        end else begin
            case (r_state_q)
                R_IDLE: begin
                    if (s_axi.S_AXI_ARVALID) begin
                        ar_id_q    <= s_axi.S_AXI_ARID;
                        ar_addr_q  <= s_axi.S_AXI_ARADDR;
                        ar_len_q   <= s_axi.S_AXI_ARLEN;
                        ar_size_q  <= s_axi.S_AXI_ARSIZE;
                        ar_burst_q <= s_axi.S_AXI_ARBURST;
                        r_cnt_q    <= '0;
                        r_state_q  <= R_FETCH;
                    end
                end
                R_FETCH: begin
                    rdata_q   <= r_in_range ? mem[r_idx] : '0;
                    rresp_q   <= r_beat_resp_d;
                    rlast_q   <= (r_cnt_q == ar_len_q);
                    r_state_q <= R_DATA;
                end
                R_DATA: begin
                    if (s_axi.S_AXI_RREADY) begin
                        if (rlast_q) begin
                            rlast_q   <= 1'b0;
                            r_state_q <= R_IDLE;
                        end else begin
                            r_cnt_q   <= r_cnt_q + 8'd1;
                            ar_addr_q <= ar_addr_d;
                            r_state_q <= R_FETCH;
                        end
                    end
                end
                default: r_state_q <= R_IDLE;
            endcase
        end
    end

    assign s_axi.S_AXI_ARREADY = (r_state_q == R_IDLE);
    assign s_axi.S_AXI_RVALID  = (r_state_q == R_DATA);
    assign s_axi.S_AXI_RID     = ar_id_q;
    assign s_axi.S_AXI_RDATA   = rdata_q;
    assign s_axi.S_AXI_RRESP   = rresp_q;
    assign s_axi.S_AXI_RLAST   = rlast_q;
endmodule

// File: tb/tb_axi_mem_responder.sv
// tb/tb_axi_mem_responder.sv - scoreboard bench for axi_mem_responder
module tb_axi_mem_responder;
    logic CLK = 1'b0;
    logic RST = 1'b1;

    axi_mem_responder_if #(.C_AXI_DATA_WIDTH(32), .C_OFFSET_WIDTH(32)) axi ();

    axi_mem_responder #(
        .C_AXI_DATA_WIDTH(32),
        .C_OFFSET_WIDTH(32),
        .MEM_WORDS_LOG2(12)
    ) dut (
        .CLK  (CLK),
        .RST  (RST),
        .s_axi(axi)
    );

    always #5 CLK = ~CLK;

    int errors = 0;
    int checks = 0;

    logic [5:0]  bq [$];   // {id, resp}
    logic [38:0] rq [$];   // {id, data, resp, last}
    logic [31:0] wbuf [0:255];
    logic [31:0] rexp [0:255];
    logic [5:0]  be;
    logic [38:0] re;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    // Monitor: pops one expectation per observed B or R handshake.
    always @(negedge CLK) begin
        if (!RST) begin
            if (axi.S_AXI_BVALID && axi.S_AXI_BREADY) begin
                if (bq.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL b_unexpected: got bid %0h bresp %0h expected none", axi.S_AXI_BID, axi.S_AXI_BRESP);
                end else begin
                    be = bq.pop_front();
                    check("bid", 64'(axi.S_AXI_BID), 64'(be[5:2]));
                    check("bresp", 64'(axi.S_AXI_BRESP), 64'(be[1:0]));
                end
            end
            if (axi.S_AXI_RVALID && axi.S_AXI_RREADY) begin
                if (rq.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL r_unexpected: got rid %0h rdata %0h expected none", axi.S_AXI_RID, axi.S_AXI_RDATA);
                end else begin
                    re = rq.pop_front();
                    check("rid", 64'(axi.S_AXI_RID), 64'(re[38:35]));
                    check("rdata", 64'(axi.S_AXI_RDATA), 64'(re[34:3]));
                    check("rresp", 64'(axi.S_AXI_RRESP), 64'(re[2:1]));
                    check("rlast", 64'(axi.S_AXI_RLAST), 64'(re[0]));
                end
            end
        end
    end

    task automatic check_reset_outputs();
        check("rst_awready", 64'(axi.S_AXI_AWREADY), 64'd1);
        check("rst_arready", 64'(axi.S_AXI_ARREADY), 64'd1);
        check("rst_wready",  64'(axi.S_AXI_WREADY),  64'd0);
        check("rst_bvalid",  64'(axi.S_AXI_BVALID),  64'd0);
        check("rst_rvalid",  64'(axi.S_AXI_RVALID),  64'd0);
        check("rst_rlast",   64'(axi.S_AXI_RLAST),   64'd0);
        check("rst_bresp",   64'(axi.S_AXI_BRESP),   64'd0);
        check("rst_rresp",   64'(axi.S_AXI_RRESP),   64'd0);
        check("rst_rdata",   64'(axi.S_AXI_RDATA),   64'd0);
        check("rst_bid",     64'(axi.S_AXI_BID),     64'd0);
        check("rst_rid",     64'(axi.S_AXI_RID),     64'd0);
    endtask

    task automatic do_aw(input logic [3:0] id, input logic [31:0] addr, input logic [7:0] len,
                         input logic [2:0] size, input logic [1:0] burst);
        int n = 0;
        axi.S_AXI_AWID = id; axi.S_AXI_AWADDR = addr; axi.S_AXI_AWLEN = len;
        axi.S_AXI_AWSIZE = size; axi.S_AXI_AWBURST = burst; axi.S_AXI_AWVALID = 1'b1;
        @(negedge CLK);
        while (!axi.S_AXI_AWREADY && n < 100) begin n++; @(negedge CLK); end
        if (n >= 100) check("awready_timeout", 64'd1, 64'd0);
        @(posedge CLK); #1;
        axi.S_AXI_AWVALID = 1'b0;
    endtask

    task automatic do_w(input logic [31:0] data, input logic [3:0] strb, input logic last);
        int n = 0;
        axi.S_AXI_WDATA = data; axi.S_AXI_WSTRB = strb; axi.S_AXI_WLAST = last;
        axi.S_AXI_WVALID = 1'b1;
        @(negedge CLK);
        while (!axi.S_AXI_WREADY && n < 100) begin n++; @(negedge CLK); end
        if (n >= 100) check("wready_timeout", 64'd1, 64'd0);
        @(posedge CLK); #1;
        axi.S_AXI_WVALID = 1'b0;
    endtask

    task automatic do_ar(input logic [3:0] id, input logic [31:0] addr, input logic [7:0] len,
                         input logic [2:0] size, input logic [1:0] burst);
        int n = 0;
        axi.S_AXI_ARID = id; axi.S_AXI_ARADDR = addr; axi.S_AXI_ARLEN = len;
        axi.S_AXI_ARSIZE = size; axi.S_AXI_ARBURST = burst; axi.S_AXI_ARVALID = 1'b1;
        @(negedge CLK);
        while (!axi.S_AXI_ARREADY && n < 100) begin n++; @(negedge CLK); end
        if (n >= 100) check("arready_timeout", 64'd1, 64'd0);
        @(posedge CLK); #1;
        axi.S_AXI_ARVALID = 1'b0;
    endtask

    task automatic write_burst(input logic [3:0] id, input logic [31:0] addr, input logic [7:0] len,
                               input logic [2:0] size, input logic [1:0] burst, input logic [3:0] strb,
                               input int last_at, input logic [1:0] resp);
        bq.push_back({id, resp});
        do_aw(id, addr, len, size, burst);
        for (int i = 0; i <= int'(len); i++) do_w(wbuf[i], strb, i == last_at);
    endtask

    task automatic read_burst(input logic [3:0] id, input logic [31:0] addr, input logic [7:0] len,
                              input logic [2:0] size, input logic [1:0] burst, input logic [1:0] resp);
        for (int i = 0; i <= int'(len); i++) rq.push_back({id, rexp[i], resp, i == int'(len)});
        do_ar(id, addr, len, size, burst);
    endtask

    task automatic drain();
        int n = 0;
        while ((bq.size() != 0 || rq.size() != 0) && n < 3000) begin n++; @(negedge CLK); end
        check("drain_timeout", 64'(n >= 3000), 64'd0);
        @(posedge CLK); #1;
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        axi.S_AXI_AWID = '0; axi.S_AXI_AWADDR = '0; axi.S_AXI_AWLEN = '0; axi.S_AXI_AWSIZE = '0;
        axi.S_AXI_AWBURST = '0; axi.S_AXI_AWVALID = 1'b0;
        axi.S_AXI_WDATA = '0; axi.S_AXI_WSTRB = '0; axi.S_AXI_WLAST = 1'b0; axi.S_AXI_WVALID = 1'b0;
        axi.S_AXI_BREADY = 1'b1;
        axi.S_AXI_ARID = '0; axi.S_AXI_ARADDR = '0; axi.S_AXI_ARLEN = '0; axi.S_AXI_ARSIZE = '0;
        axi.S_AXI_ARBURST = '0; axi.S_AXI_ARVALID = 1'b0;
        axi.S_AXI_RREADY = 1'b1;

        repeat (3) @(posedge CLK);
        @(negedge CLK);
        check_reset_outputs();
        @(posedge CLK); #1;
        RST = 1'b0;

        // Four-beat INCR write then read-back.
        for (int i = 0; i < 4; i++) begin
            wbuf[i] = 32'h11111111 * (i + 1);
            rexp[i] = 32'h11111111 * (i + 1);
        end
        write_burst(4'h3, 32'h10, 8'd3, 3'b010, 2'b01, 4'hF, 3, 2'b00);
        drain();
        read_burst(4'h5, 32'h10, 8'd3, 3'b010, 2'b01, 2'b00);
        drain();

        // Byte-strobe merge.
        wbuf[0] = 32'hAABBCCDD;
        write_burst(4'h1, 32'h20, 8'd0, 3'b010, 2'b01, 4'hF, 0, 2'b00);
        drain();
        wbuf[0] = 32'h0000EE00;
        write_burst(4'h1, 32'h20, 8'd0, 3'b010, 2'b01, 4'h2, 0, 2'b00);
        drain();
        rexp[0] = 32'hAABBEEDD;
        read_burst(4'h2, 32'h20, 8'd0, 3'b010, 2'b01, 2'b00);
        drain();

        // Read latency and hold under RREADY low.
        wbuf[0] = 32'hCAFEF00D;
        write_burst(4'h4, 32'h0, 8'd0, 3'b010, 2'b01, 4'hF, 0, 2'b00);
        drain();
        axi.S_AXI_RREADY = 1'b0;
        rq.push_back({4'h6, 32'hCAFEF00D, 2'b00, 1'b1});
        do_ar(4'h6, 32'h0, 8'd0, 3'b010, 2'b01);
        @(negedge CLK);
        check("rvalid_cycle1", 64'(axi.S_AXI_RVALID), 64'd0);
        check("arready_fetch", 64'(axi.S_AXI_ARREADY), 64'd0);
        @(negedge CLK);
        check("rvalid_cycle2", 64'(axi.S_AXI_RVALID), 64'd1);
        for (int i = 0; i < 5; i++) begin
            check("hold_rdata", 64'(axi.S_AXI_RDATA), 64'hCAFEF00D);
            check("hold_rvalid", 64'(axi.S_AXI_RVALID), 64'd1);
            check("hold_arready", 64'(axi.S_AXI_ARREADY), 64'd0);
            @(negedge CLK);
        end
        @(posedge CLK); #1;
        axi.S_AXI_RREADY = 1'b1;
        drain();

        // Out-of-range write and read.
        wbuf[0] = 32'hDEADBEEF;
        write_burst(4'h2, 32'h4000, 8'd0, 3'b010, 2'b01, 4'hF, 0, 2'b11);
        drain();
        rexp[0] = 32'hCAFEF00D;
        read_burst(4'h3, 32'h0, 8'd0, 3'b010, 2'b01, 2'b00);
        drain();
        rexp[0] = 32'h0;
        read_burst(4'h4, 32'h4000, 8'd0, 3'b010, 2'b01, 2'b11);
        drain();

        // Early WLAST gives SLVERR but data still lands.
        wbuf[0] = 32'h1; wbuf[1] = 32'h2;
        write_burst(4'h7, 32'h30, 8'd1, 3'b010, 2'b01, 4'hF, 0, 2'b10);
        drain();
        rexp[0] = 32'h2;
        read_burst(4'hC, 32'h34, 8'd0, 3'b010, 2'b01, 2'b00);
        drain();

        // Non-word SIZE on both channels.
        wbuf[0] = 32'h55;
        write_burst(4'hB, 32'h30, 8'd0, 3'b001, 2'b01, 4'hF, 0, 2'b10);
        drain();
        rexp[0] = 32'h55;
        read_burst(4'hB, 32'h30, 8'd0, 3'b000, 2'b01, 2'b10);
        drain();

        // FIXED bursts, including the 256-beat maximum.
        wbuf[0] = 32'h12345678;
        write_burst(4'h8, 32'h8, 8'd0, 3'b010, 2'b01, 4'hF, 0, 2'b00);
        drain();
        for (int i = 0; i < 256; i++) rexp[i] = 32'h12345678;
        read_burst(4'h9, 32'h8, 8'd2, 3'b010, 2'b00, 2'b00);
        drain();
        read_burst(4'hA, 32'h8, 8'd255, 3'b010, 2'b00, 2'b00);
        drain();

        // Reset while beat 2 of an eight-beat read is being fetched.
        for (int i = 0; i < 8; i++) wbuf[i] = 32'h100 + i;
        write_burst(4'h1, 32'h100, 8'd7, 3'b010, 2'b01, 4'hF, 7, 2'b00);
        drain();
        rq.push_back({4'hD, 32'h100, 2'b00, 1'b0});
        rq.push_back({4'hD, 32'h101, 2'b00, 1'b0});
        do_ar(4'hD, 32'h100, 8'd7, 3'b010, 2'b01);
        repeat (4) @(posedge CLK);
        #1 RST = 1'b1;
        @(posedge CLK); #1;
        RST = 1'b0;
        @(negedge CLK);
        check_reset_outputs();
        check("beats_before_reset", 64'(rq.size()), 64'd0);
        rq.delete();
        repeat (4) @(negedge CLK);
        check("rvalid_after_abort", 64'(axi.S_AXI_RVALID), 64'd0);
        @(posedge CLK); #1;
        for (int i = 0; i < 8; i++) rexp[i] = 32'h100 + i;
        read_burst(4'hE, 32'h100, 8'd7, 3'b010, 2'b01, 2'b00);
        drain();
        rexp[0] = 32'hAABBEEDD;
        read_burst(4'hF, 32'h20, 8'd0, 3'b010, 2'b01, 2'b00);
        drain();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
